// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for the ALU sharing arbiter: data word, ALU opcode and flag bundle.
package alu_share_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4
  } aluop_t;

  typedef struct packed {
    logic negative;
    logic overflow;
    logic zero;
  } alu_flags_t;

  localparam aluop_t ALU_IDLE_OP = ALU_ADD;

  // Modulo-n increment for round-robin indices; v never exceeds 2n-1.
  function automatic int rr_wrap(int v, int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-side bus of the arbiter and the arbiter-to-ALU connection.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  word_t           req_a [NREQ];
  word_t           req_b [NREQ];
  aluop_t          req_op [NREQ];
  logic [NREQ-1:0] resp_valid;
  logic [NREQ-1:0] resp_ready;
  word_t           resp_out [NREQ];
  alu_flags_t      resp_flags [NREQ];

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_out, resp_flags
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_out, resp_flags
  );
endinterface

interface alu_if
  import alu_share_arbiter_pkg::*;
  ();
  word_t  port_A;
  word_t  port_B;
  aluop_t aluop;
  word_t  output_port;
  logic   negative;
  logic   overflow;
  logic   zero;

  // The user of the ALU drives operands and consumes results.
  modport alu (
    output port_A, port_B, aluop,
    input  output_port, negative, overflow, zero
  );

  modport unit (
    input  port_A, port_B, aluop,
    output output_port, negative, overflow, zero
  );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Reusable round-robin arbiter: one-hot grant from an eligibility vector, searching from ptr.
module rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            grant_valid,
  output logic [PW-1:0]   grant_idx,
  output logic [PW-1:0]   next_ptr
);

  logic [PW-1:0] cand [NREQ];

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      cand[k] = PW'(rr_wrap(int'(ptr) + k, NREQ));
    end
  end

  // Scan from the farthest offset down so the closest eligible index to ptr wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (eligible[cand[k]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[k];
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
    next_ptr = grant_valid ? PW'(rr_wrap(int'(grant_idx) + 1, NREQ)) : ptr;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters with round-robin grants
// and a per-requester response register held until acknowledged.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus,
  alu_if.alu                 alu_port
);

  localparam int PW = $clog2(NREQ);

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic            grant_valid;
  logic [PW-1:0]   grant_idx;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   next_ptr;
  logic [NREQ-1:0] resp_valid;
  word_t           resp_out [NREQ];
  alu_flags_t      resp_flags [NREQ];

  // A slot draining this cycle may be refilled; reset suppresses every grant.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = !rst && bus.req_valid[i] && (!resp_valid[i] || bus.resp_ready[i]);
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .eligible    (eligible),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .next_ptr    (next_ptr)
  );

  always_comb begin
    alu_port.port_A = '0;
    alu_port.port_B = '0;
    alu_port.aluop  = ALU_IDLE_OP;
    if (grant_valid) begin
      alu_port.port_A = bus.req_a[grant_idx];
      alu_port.port_B = bus.req_b[grant_idx];
      alu_port.aluop  = bus.req_op[grant_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      resp_valid <= '0;
      for (int i = 0; i < NREQ; i++) begin
        resp_out[i]   <= '0;
        resp_flags[i] <= '0;
      end
    end else begin
      rr_ptr <= next_ptr;
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i]) begin
          resp_valid[i] <= 1'b1;
          resp_out[i]   <= alu_port.output_port;
          resp_flags[i] <= '{negative: alu_port.negative,
                             overflow: alu_port.overflow,
                             zero:     alu_port.zero};
        end else if (bus.resp_ready[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_out   = resp_out;
  assign bus.resp_flags = resp_flags;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: the bench plays the ALU and checks each consumed response.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NREQ = 2;

  typedef struct {
    word_t      a;
    word_t      b;
    aluop_t     op;
    word_t      out;
    logic [2:0] fl;
  } vec_t;

  typedef struct {
    word_t      out;
    logic [2:0] fl;
  } exp_t;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_NEG  = 3'b100;
  localparam logic [2:0] F_ZERO = 3'b001;
  localparam logic [2:0] F_NV   = 3'b110;

  logic clk;
  logic rst;

  alu_share_arbiter_if #(.NREQ(NREQ)) bus ();
  alu_if alu_bus ();

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_port (alu_bus)
  );

  int   checks_total  = 0;
  int   checks_passed = 0;
  vec_t cur_vec [NREQ];
  exp_t sb_q [NREQ][$];
  exp_t popped;
  word_t alu_r;
  logic  alu_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU sitting outside the block under test
  always_comb begin
    alu_r = '0;
    alu_v = 1'b0;
    case (alu_bus.aluop)
      ALU_ADD: begin
        alu_r = alu_bus.port_A + alu_bus.port_B;
        alu_v = (alu_bus.port_A[31] == alu_bus.port_B[31]) && (alu_r[31] != alu_bus.port_A[31]);
      end
      ALU_SUB: begin
        alu_r = alu_bus.port_A - alu_bus.port_B;
        alu_v = (alu_bus.port_A[31] != alu_bus.port_B[31]) && (alu_r[31] != alu_bus.port_A[31]);
      end
      ALU_AND: alu_r = alu_bus.port_A & alu_bus.port_B;
      ALU_OR:  alu_r = alu_bus.port_A | alu_bus.port_B;
      ALU_XOR: alu_r = alu_bus.port_A ^ alu_bus.port_B;
      default: alu_r = '0;
    endcase
    alu_bus.output_port = alu_r;
    alu_bus.negative    = alu_r[31];
    alu_bus.overflow    = alu_v;
    alu_bus.zero        = (alu_r == '0);
  end

  function automatic vec_t mk(word_t a, word_t b, aluop_t op, word_t out, logic [2:0] fl);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.out = out; v.fl = fl;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input int i, input vec_t v);
    bus.req_a[i]  = v.a;
    bus.req_b[i]  = v.b;
    bus.req_op[i] = v.op;
    cur_vec[i]    = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: responses consumed at the coming edge are popped and checked before
  // any newly accepted request for the same slot is pushed.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) sb_q[i].delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.resp_valid[i] && bus.resp_ready[i]) begin
          if (sb_q[i].size() == 0) begin
            checks_total++;
            $display("[TB] FAIL sb_unexpected: requester %0d presented %0h with nothing expected", i, bus.resp_out[i]);
          end else begin
            popped = sb_q[i].pop_front();
            check_output($sformatf("sb_out%0d", i), bus.resp_out[i], popped.out);
            check_output($sformatf("sb_flags%0d", i), 32'(bus.resp_flags[i]), 32'(popped.fl));
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb_q[i].push_back('{out: cur_vec[i].out, fl: cur_vec[i].fl});
        end
      end
    end
  end

  vec_t rot0 [2];
  vec_t rot1 [2];
  logic [1:0] rot_grant [4];
  int idx0, idx1;

  initial begin
    rot0[0] = mk(32'd1, 32'd1, ALU_ADD, 32'd2, F_NONE);
    rot0[1] = mk(32'd3, 32'd5, ALU_SUB, 32'hFFFF_FFFE, F_NEG);
    rot1[0] = mk(32'hF0F0, 32'h0FF0, ALU_AND, 32'h00F0, F_NONE);
    rot1[1] = mk(32'd5, 32'd5, ALU_XOR, 32'd0, F_ZERO);
    rot_grant[0] = 2'b10;
    rot_grant[1] = 2'b01;
    rot_grant[2] = 2'b10;
    rot_grant[3] = 2'b01;

    // Reset held with both requesters asking
    rst = 1'b1;
    bus.resp_ready = 2'b00;
    apply_stimulus(0, mk(32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000, F_NV));
    apply_stimulus(1, mk(32'd2, 32'd3, ALU_ADD, 32'd5, F_NONE));
    bus.req_valid = 2'b11;
    repeat (3) begin
      @(negedge clk);
      check_output("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check_output("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      check_output("rst_alu_op", 32'(alu_bus.aluop), 32'(ALU_ADD));
      check_output("rst_alu_A", alu_bus.port_A, 32'h0);
    end
    step();
    rst = 1'b0;

    // First grant after reset goes to requester 0, which drives the ALU
    @(negedge clk);
    check_output("first_grant", 32'(bus.req_ready), 32'h1);
    check_output("drive_A", alu_bus.port_A, 32'h7FFF_FFFF);
    check_output("drive_B", alu_bus.port_B, 32'h1);
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check_output("single_valid", 32'(bus.resp_valid), 32'h1);
    check_output("single_out", bus.resp_out[0], 32'h8000_0000);
    check_output("single_flags", 32'(bus.resp_flags[0]), 32'(F_NV));
    check_output("idle_alu_op", 32'(alu_bus.aluop), 32'(ALU_ADD));
    step();
    bus.resp_ready = 2'b11;
    step();

    // Rotation: pointer sits at 1 after the single op
    idx0 = 0;
    idx1 = 0;
    apply_stimulus(0, rot0[0]);
    apply_stimulus(1, rot1[0]);
    bus.req_valid = 2'b11;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("rot_grant%0d", c), 32'(bus.req_ready), 32'(rot_grant[c]));
      step();
      if (rot_grant[c][0] && idx0 < 1) begin idx0++; apply_stimulus(0, rot0[idx0]); end
      if (rot_grant[c][1] && idx1 < 1) begin idx1++; apply_stimulus(1, rot1[idx1]); end
    end

    // Backpressure on requester 1
    apply_stimulus(0, mk(32'h10, 32'h20, ALU_ADD, 32'h30, F_NONE));
    apply_stimulus(1, mk(32'h1200, 32'h0034, ALU_OR, 32'h1234, F_NONE));
    bus.resp_ready = 2'b01;
    @(negedge clk);
    check_output("bp_first_grant", 32'(bus.req_ready), 32'h2);
    step();
    apply_stimulus(1, mk(32'd1, 32'd2, ALU_SUB, 32'hFFFF_FFFF, F_NEG));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_output($sformatf("bp_grant%0d", c), 32'(bus.req_ready), 32'h1);
      check_output($sformatf("bp_hold_valid%0d", c), 32'(bus.resp_valid[1]), 32'h1);
      check_output($sformatf("bp_hold_out%0d", c), bus.resp_out[1], 32'h1234);
      step();
    end
    bus.resp_ready = 2'b11;
    @(negedge clk);
    check_output("bp_release_grant", 32'(bus.req_ready), 32'h2);
    step();

    // Same-cycle drain and refill on requester 0
    bus.req_valid = 2'b01;
    apply_stimulus(0, mk(32'd8, 32'd8, ALU_ADD, 32'h10, F_NONE));
    @(negedge clk);
    check_output("refill_pre_grant", 32'(bus.req_ready), 32'h1);
    step();
    apply_stimulus(0, mk(32'd5, 32'd5, ALU_SUB, 32'h0, F_ZERO));
    @(negedge clk);
    check_output("refill_valid_before", 32'(bus.resp_valid[0]), 32'h1);
    check_output("refill_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    @(negedge clk);
    check_output("refill_valid_after", 32'(bus.resp_valid[0]), 32'h1);
    check_output("refill_out", bus.resp_out[0], 32'h0);
    check_output("refill_flags", 32'(bus.resp_flags[0]), 32'(F_ZERO));
    step();

    // Reset arriving while requester 1 would be granted
    rst = 1'b1;
    bus.req_valid = 2'b10;
    apply_stimulus(0, mk(32'hFFFF, 32'h00FF, ALU_AND, 32'h00FF, F_NONE));
    apply_stimulus(1, mk(32'd3, 32'd4, ALU_ADD, 32'd7, F_NONE));
    @(negedge clk);
    check_output("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    check_output("mid_rst_alu_op", 32'(alu_bus.aluop), 32'(ALU_ADD));
    check_output("mid_rst_alu_A", alu_bus.port_A, 32'h0);
    step();
    rst = 1'b0;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b11;
    @(negedge clk);
    check_output("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_output("mid_rst_ptr_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check_output("post_rst_valid", 32'(bus.resp_valid), 32'h1);
    step();
    @(negedge clk);
    check_output("final_resp_valid", 32'(bus.resp_valid), 32'h0);
    check_output("final_q0_empty", 32'(sb_q[0].size()), 32'h0);
    check_output("final_q1_empty", 32'(sb_q[1].size()), 32'h0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
